add_share_ctrl: RTL and testbench

- Arbitrates two requesters onto one shared SLICE_W-bit adder slice (with carry-in) and sequences multi-slice additions, least-significant slice first, with the carry chained through a register.
- Sits between the top-level pin wrapper and the adder datapath.
- Turns the single narrow adder into a shared, wide, handshaked arithmetic resource.

---
 rtl/add_share_pkg.sv | 20 ++
 rtl/add_share_ctrl_if.sv | 27 ++
 rtl/add_slice.sv | 18 +
 rtl/add_share_ctrl.sv | 165 ++++++++++++++++
 tb/tb_add_share_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_share_pkg.sv
// Shared types and constants for the two-requester, slice-sequenced adder controller.
package add_share_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StResp
    } state_e;

    localparam int unsigned SLICE_W_DEF = 6;
    localparam int unsigned NSLICE_DEF  = 2;
    localparam int unsigned NREQ        = 2;

    function automatic int unsigned op_w(input int unsigned slice_w, input int unsigned nslice);
        return slice_w * nslice;
    endfunction

    localparam int unsigned OP_W_DEF = op_w(SLICE_W_DEF, NSLICE_DEF);

endpackage

// File: rtl/add_share_ctrl_if.sv
// Request/response bundle between the requesters and add_share_ctrl.
interface add_share_ctrl_if #(
    parameter int unsigned OP_W = 12
);
    logic [add_share_pkg::NREQ-1:0]      req_valid;
    logic [add_share_pkg::NREQ-1:0]      req_ready;
    logic [add_share_pkg::NREQ*OP_W-1:0] req_a;
    logic [add_share_pkg::NREQ*OP_W-1:0] req_b;
    logic [add_share_pkg::NREQ-1:0]      req_cin;
    logic [add_share_pkg::NREQ-1:0]      req_sub;
    logic                                rsp_valid;
    logic                                rsp_ready;
    logic                                rsp_id;
    logic [OP_W-1:0]                     rsp_sum;
    logic                                rsp_cout;
    logic                                busy;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/add_slice.sv
// Combinational W-bit adder with carry-in and carry-out; the single shared arithmetic slice.
module add_slice #(
    parameter int unsigned W = 6
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);
    logic [W:0] full;

    always_comb begin
        full   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
        sum_o  = full[W-1:0];
        cout_o = full[W];
    end
endmodule

// File: rtl/add_share_ctrl.sv
// Round-robin arbiter that runs wide additions LSB-slice first through one shared add_slice.
// Optional subtract mode is enabled by defining ADDSHARE_SUB_EN.
module add_share_ctrl
    import add_share_pkg::*;
#(
    parameter int unsigned SLICE_W = SLICE_W_DEF,
    parameter int unsigned NSLICE  = NSLICE_DEF
) (
    input logic             clk,
    input logic             rst,
    add_share_ctrl_if.slave bus
);
    localparam int unsigned OP_W = op_w(SLICE_W, NSLICE);
    localparam int unsigned CntW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NSLICE - 1);

    state_e          state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0] a_q, a_d;
    logic [OP_W-1:0] b_q, b_d;
    logic [OP_W-1:0] sum_q, sum_d;
    logic            cin_q, cin_d;
    logic            id_q, id_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;

    logic            any_valid;
    logic            grant;
    logic [NREQ-1:0] req_ready;

    logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
    logic               first_cin, c_in, c_out;

`ifdef ADDSHARE_SUB_EN
    logic sub_q, sub_d;
`else
    logic [NREQ-1:0] unused_req_sub;
    assign unused_req_sub = bus.req_sub;
`endif

    // Requester rr_ptr wins a tie; otherwise whichever one is valid.
    always_comb begin
        any_valid = |bus.req_valid;
        grant     = rr_ptr_q;
        if (!bus.req_valid[rr_ptr_q]) begin
            grant = ~rr_ptr_q;
        end
    end

    always_comb begin
        a_sl      = a_q[int'(cnt_q) * SLICE_W +: SLICE_W];
        b_sl      = b_q[int'(cnt_q) * SLICE_W +: SLICE_W];
        first_cin = cin_q;
`ifdef ADDSHARE_SUB_EN
        // a - b == a + ~b + 1, so the caller's carry-in is overridden.
        if (sub_q) begin
            b_sl      = ~b_sl;
            first_cin = 1'b1;
        end
`endif
        c_in = (cnt_q == '0) ? first_cin : carry_q;
    end

    add_slice #(
        .W(SLICE_W)
    ) u_slice (
        .a_i   (a_sl),
        .b_i   (b_sl),
        .cin_i (c_in),
        .sum_o (s_sl),
        .cout_o(c_out)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cin_d     = cin_q;
        id_d      = id_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        req_ready = '0;
`ifdef ADDSHARE_SUB_EN
        sub_d     = sub_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    req_ready[grant] = 1'b1;
                    a_d      = grant ? bus.req_a[OP_W +: OP_W] : bus.req_a[0 +: OP_W];
                    b_d      = grant ? bus.req_b[OP_W +: OP_W] : bus.req_b[0 +: OP_W];
                    cin_d    = bus.req_cin[grant];
                    id_d     = grant;
                    rr_ptr_d = ~grant;
                    cnt_d    = '0;
`ifdef ADDSHARE_SUB_EN
                    sub_d    = bus.req_sub[grant];
`endif
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                sum_d[int'(cnt_q) * SLICE_W +: SLICE_W] = s_sl;
                carry_d = c_out;
                if (cnt_q == CntLast) begin
                    cout_d  = c_out;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            cin_q    <= 1'b0;
            id_q     <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
`ifdef ADDSHARE_SUB_EN
            sub_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            cin_q    <= cin_d;
            id_q     <= id_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
`ifdef ADDSHARE_SUB_EN
            sub_q    <= sub_d;
`endif
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_add_share_ctrl.sv
// Directed self-checking bench for add_share_ctrl (default 2 x 6-bit slices, 12-bit operands).
module tb_add_share_ctrl;
    import add_share_pkg::*;

    localparam int unsigned OP_W = OP_W_DEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add_share_ctrl_if #(.OP_W(OP_W)) bus ();

    add_share_ctrl #(
        .SLICE_W(SLICE_W_DEF),
        .NSLICE (NSLICE_DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit two_hot_seen = 1'b0;

    always @(negedge clk) begin
        if (bus.req_ready === 2'b11) two_hot_seen = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait for accept, then wait (bounded) for rsp_valid.
    task automatic run_one(input bit id, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                           input logic cin, input logic sub, output logic [1:0] rdy,
                           output int lat, output bit timeout);
        if (id) begin
            bus.req_a[OP_W +: OP_W] = a;
            bus.req_b[OP_W +: OP_W] = b;
        end else begin
            bus.req_a[0 +: OP_W] = a;
            bus.req_b[0 +: OP_W] = b;
        end
        bus.req_cin[id]   = cin;
        bus.req_sub[id]   = sub;
        bus.req_valid     = 2'b00;
        bus.req_valid[id] = 1'b1;
        #1;
        rdy = bus.req_ready;
        step();
        bus.req_valid = 2'b00;
        lat = 0;
        timeout = 1'b0;
        while (bus.rsp_valid !== 1'b1) begin
            if (lat >= 20) begin
                timeout = 1'b1;
                break;
            end
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 2'b00;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_cin = '0;
        bus.req_sub = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_total++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid);
        else n_pass++;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
        else n_pass++;
        n_total++;
        if (bus.rsp_sum !== 12'h000) $display("FAIL reset_sum: got %h want 000", bus.rsp_sum);
        else n_pass++;
        n_total++;
        if (bus.rsp_id !== 1'b0 || bus.rsp_cout !== 1'b0)
            $display("FAIL reset_id_cout: got %b/%b want 0/0", bus.rsp_id, bus.rsp_cout);
        else n_pass++;
        n_total++;
        if (bus.req_ready !== 2'b00) $display("FAIL reset_ready_idle: got %b want 00", bus.req_ready);
        else n_pass++;
        // rr_ptr resets to 0, so requester 0 wins the tie.
        bus.req_valid = 2'b11;
        #1;
        n_total++;
        if (bus.req_ready !== 2'b01) $display("FAIL reset_rr_ptr: got %b want 01", bus.req_ready);
        else n_pass++;
        bus.req_valid = 2'b00;
        #1;
    endtask

    task automatic test_single_add();
        logic [1:0] rdy;
        int lat;
        bit to;
        bus.rsp_ready = 1'b1;
        run_one(1'b0, 12'h03F, 12'h001, 1'b0, 1'b0, rdy, lat, to);
        n_total++;
        if (rdy !== 2'b01) $display("FAIL add_ready: got %b want 01", rdy);
        else n_pass++;
        n_total++;
        if (to || lat != 2) $display("FAIL add_latency: got %0d (timeout %0d) want 2", lat, to);
        else n_pass++;
        n_total++;
        if (bus.rsp_sum !== 12'h040) $display("FAIL add_sum: got %h want 040", bus.rsp_sum);
        else n_pass++;
        n_total++;
        if (bus.rsp_cout !== 1'b0 || bus.rsp_id !== 1'b0)
            $display("FAIL add_cout_id: got %b/%b want 0/0", bus.rsp_cout, bus.rsp_id);
        else n_pass++;
        step();
        n_total++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL add_return_idle: got valid %b busy %b want 0 0", bus.rsp_valid, bus.busy);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [1:0] rdy;
        int lat;
        bit to;
        bus.rsp_ready = 1'b1;
        run_one(1'b0, 12'hFFF, 12'h001, 1'b1, 1'b0, rdy, lat, to);
        n_total++;
        if (to || bus.rsp_sum !== 12'h001) $display("FAIL ovf_sum: got %h want 001", bus.rsp_sum);
        else n_pass++;
        n_total++;
        if (bus.rsp_cout !== 1'b1) $display("FAIL ovf_cout: got %b want 1", bus.rsp_cout);
        else n_pass++;
        step();
    endtask

    task automatic test_contention();
        logic [OP_W-1:0] exp_sum [2];
        logic            exp_cout[2];
        bit g;
        int w;
        exp_sum[0] = 12'h579;
        exp_cout[0] = 1'b0;
        exp_sum[1] = 12'h001;
        exp_cout[1] = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        two_hot_seen = 1'b0;
        bus.req_a = {12'hABC, 12'h123};
        bus.req_b = {12'h544, 12'h456};
        bus.req_cin = 2'b10;
        bus.req_sub = 2'b00;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (bus.req_ready === 2'b00 && w < 20) begin
                step();
                w++;
            end
            n_total++;
            if (bus.req_ready !== 2'b01 && bus.req_ready !== 2'b10)
                $display("FAIL cont_ready_onehot[%0d]: got %b want 01 or 10", k, bus.req_ready);
            else n_pass++;
            g = bus.req_ready[1];
            n_total++;
            if (g !== k[0]) $display("FAIL cont_grant_order[%0d]: got %0d want %0d", k, g, k[0]);
            else n_pass++;
            step();
            w = 0;
            while (bus.rsp_valid !== 1'b1 && w < 20) begin
                step();
                w++;
            end
            n_total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== g)
                $display("FAIL cont_rsp_id[%0d]: got %b want %0d", k, bus.rsp_id, g);
            else n_pass++;
            n_total++;
            if (bus.rsp_sum !== exp_sum[g] || bus.rsp_cout !== exp_cout[g])
                $display("FAIL cont_rsp_sum[%0d]: got %h/%b want %h/%b", k, bus.rsp_sum,
                         bus.rsp_cout, exp_sum[g], exp_cout[g]);
            else n_pass++;
            step();
        end
        bus.req_valid = 2'b00;
        n_total++;
        if (two_hot_seen) $display("FAIL cont_two_hot: got 11 on req_ready want at most one bit");
        else n_pass++;
        step();
    endtask

    task automatic test_backpressure();
        logic [1:0] rdy;
        int lat;
        bit to;
        bus.rsp_ready = 1'b0;
        run_one(1'b1, 12'h0F0, 12'h00F, 1'b0, 1'b0, rdy, lat, to);
        n_total++;
        if (to) $display("FAIL bp_rsp_timeout: got no rsp_valid want rsp_valid");
        else n_pass++;
        bus.req_valid = 2'b01;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 12'h0FF || bus.rsp_id !== 1'b1)
                $display("FAIL bp_hold[%0d]: got %b/%h/%b want 1/0ff/1", i, bus.rsp_valid,
                         bus.rsp_sum, bus.rsp_id);
            else n_pass++;
            n_total++;
            if (bus.req_ready !== 2'b00)
                $display("FAIL bp_ready[%0d]: got %b want 00", i, bus.req_ready);
            else n_pass++;
            step();
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        step();
        n_total++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL bp_release: got valid %b busy %b want 0 0", bus.rsp_valid, bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_calc();
        logic [1:0] rdy;
        int lat;
        bit to;
        bit seen;
        bus.rsp_ready = 1'b1;
        bus.req_a[OP_W +: OP_W] = 12'h0AA;
        bus.req_b[OP_W +: OP_W] = 12'h011;
        bus.req_cin = 2'b00;
        bus.req_valid = 2'b10;
        #1;
        step();
        bus.req_valid = 2'b00;
        n_total++;
        if (bus.busy !== 1'b1) $display("FAIL rmc_in_calc: got busy %b want 1", bus.busy);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_total++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL rmc_state: got valid %b busy %b want 0 0", bus.rsp_valid, bus.busy);
        else n_pass++;
        n_total++;
        if (bus.rsp_sum !== 12'h000 || bus.rsp_id !== 1'b0 || bus.rsp_cout !== 1'b0)
            $display("FAIL rmc_outputs: got %h/%b/%b want 000/0/0", bus.rsp_sum, bus.rsp_id,
                     bus.rsp_cout);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
            step();
        end
        n_total++;
        if (seen) $display("FAIL rmc_no_response: got rsp_valid want none");
        else n_pass++;
        run_one(1'b0, 12'h001, 12'h002, 1'b0, 1'b0, rdy, lat, to);
        n_total++;
        if (to || bus.rsp_sum !== 12'h003 || lat != 2)
            $display("FAIL rmc_next_op: got %h lat %0d want 003 lat 2", bus.rsp_sum, lat);
        else n_pass++;
        step();
    endtask

    task automatic test_sub();
        logic [1:0] rdy;
        int lat;
        bit to;
        logic [OP_W-1:0] exp_sum;
        logic exp_cout;
`ifdef ADDSHARE_SUB_EN
        exp_sum = 12'h0FF;
        exp_cout = 1'b1;
`else
        exp_sum = 12'h101;
        exp_cout = 1'b0;
`endif
        bus.rsp_ready = 1'b1;
        run_one(1'b0, 12'h100, 12'h001, 1'b0, 1'b1, rdy, lat, to);
        n_total++;
        if (to || bus.rsp_sum !== exp_sum || bus.rsp_cout !== exp_cout)
            $display("FAIL sub_result: got %h/%b want %h/%b", bus.rsp_sum, bus.rsp_cout, exp_sum,
                     exp_cout);
        else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_overflow();
        test_contention();
        test_backpressure();
        test_reset_mid_calc();
        test_sub();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
